// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: passes non-memory ops through, sequences loads and stores
// onto a single req/ack bus, stalls the pipeline during the access and aligns/extends load data.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic        stall_req_o,
  output logic        mem_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLbu = 4'd2;
  localparam logic [3:0] OpLh  = 4'd3;
  localparam logic [3:0] OpLhu = 4'd4;
  localparam logic [3:0] OpLw  = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_misalign;
  logic [3:0]        w_sel;
  logic [31:0]       w_bus_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_data;

  assign w_is_load  = (op_i >= OpLb) && (op_i <= OpLw);
  assign w_is_store = (op_i >= OpSb) && (op_i <= OpSw);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_misalign = (((op_i == OpLh) || (op_i == OpLhu) || (op_i == OpSh)) && addr_i[0]) ||
                      (((op_i == OpLw) || (op_i == OpSw)) && (addr_i[1:0] != 2'b00));

  // Big-endian lane select and store-data replication
  always_comb begin
    w_sel       = 4'b0000;
    w_bus_wdata = 32'h0;
    unique case (op_i)
      OpLb, OpLbu: w_sel = 4'b1000 >> addr_i[1:0];
      OpLh, OpLhu: w_sel = addr_i[1] ? 4'b0011 : 4'b1100;
      OpLw:        w_sel = 4'b1111;
      OpSb: begin
        w_sel       = 4'b1000 >> addr_i[1:0];
        w_bus_wdata = {4{store_data_i[7:0]}};
      end
      OpSh: begin
        w_sel       = addr_i[1] ? 4'b0011 : 4'b1100;
        w_bus_wdata = {2{store_data_i[15:0]}};
      end
      OpSw: begin
        w_sel       = 4'b1111;
        w_bus_wdata = store_data_i;
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of the latched read word and extend it
  always_comb begin
    unique case (addr_i[1:0])
      2'd0:    w_byte = r_rdata[31:24];
      2'd1:    w_byte = r_rdata[23:16];
      2'd2:    w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = addr_i[1] ? r_rdata[15:0] : r_rdata[31:16];
    unique case (op_i)
      OpLb:    w_load_data = {{24{w_byte[7]}}, w_byte};
      OpLbu:   w_load_data = {24'h0, w_byte};
      OpLh:    w_load_data = {{16{w_half[15]}}, w_half};
      OpLhu:   w_load_data = {16'h0, w_half};
      default: w_load_data = r_rdata;
    endcase
  end

  // Access sequencer: state, timeout counter, read latch and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_is_mem && !w_misalign) begin
            r_state <= StBusy;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        StBusy: begin
          // Ack takes priority over a timeout on the same edge
          if (bus_ack_i) begin
            r_rdata <= bus_rdata_i;
            r_err   <= 1'b0;
            r_state <= StDone;
          end else if (r_cnt == CntLast) begin
            r_err   <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Output decode; reset forces everything low without waiting for a clock edge
  always_comb begin
    wdata_o     = 32'h0;
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    stall_req_o = 1'b0;
    mem_err_o   = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = 32'h0;
    bus_sel_o   = 4'b0000;
    bus_wdata_o = 32'h0;
    if (!rst) begin
      unique case (r_state)
        StIdle: begin
          wdata_o = wdata_i;
          wd_o    = wd_i;
          if (w_is_mem) begin
            if (w_misalign) mem_err_o = 1'b1;
            else            stall_req_o = 1'b1;
          end else begin
            wreg_o = wreg_i;
          end
        end
        StBusy: begin
          wdata_o     = wdata_i;
          wd_o        = wd_i;
          stall_req_o = 1'b1;
          bus_req_o   = 1'b1;
          bus_we_o    = w_is_store;
          bus_addr_o  = {addr_i[31:2], 2'b00};
          bus_sel_o   = w_sel;
          bus_wdata_o = w_bus_wdata;
        end
        StDone: begin
          wd_o = wd_i;
          if (r_err) begin
            mem_err_o = 1'b1;
          end else begin
            wreg_o  = wreg_i;
            wdata_o = w_is_load ? w_load_data : wdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: combinational IDLE vectors, load/store transaction table,
// timeout and asynchronous reset sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op_i;
  logic [31:0] addr_i, store_data_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o, stall_req_o, mem_err_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_i         (op_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .wdata_i      (wdata_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_o      (wdata_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .stall_req_o  (stall_req_o),
    .mem_err_o    (mem_err_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_sel_o    (bus_sel_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rdata_i  (bus_rdata_i),
    .bus_ack_i    (bus_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    bit          chk_data;
    logic [31:0] e_wdata;
    logic        e_wreg;
    logic        e_stall;
    logic        e_err;
  } comb_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    int          ack_after;
    logic [3:0]  e_sel;
    logic [31:0] e_bwdata;
    logic        e_we;
    logic [31:0] e_wdata;
  } mem_vec_t;

  comb_vec_t ctab[11];
  mem_vec_t  mtab[13];

  // Issue one access; returns at mid-cycle of DONE (first cycle where bus_req_o is low again).
  // ack_after = index of the BUSY cycle whose closing edge sees bus_ack_i, -1 for never.
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rd, input int ack_after, input logic [3:0] e_sel,
                         input logic [31:0] e_bwdata, input logic e_we,
                         output int busy_n, output int stall_n);
    bit bus_bad = 1'b0;
    bit done    = 1'b0;
    @(negedge clk);
    op_i = op; addr_i = addr; store_data_i = sd; bus_ack_i = 1'b0; bus_rdata_i = 32'hDEAD_DEAD;
    #1;
    stall_n = stall_req_o ? 1 : 0;
    busy_n  = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      bus_ack_i = 1'b0; bus_rdata_i = 32'hDEAD_DEAD;
      #1;
      if (stall_req_o) stall_n++;
      if (!bus_req_o) begin
        done = 1'b1;
        break;
      end
      busy_n++;
      if (bus_addr_o !== {addr[31:2], 2'b00} || bus_sel_o !== e_sel || bus_we_o !== e_we ||
          (e_we && bus_wdata_o !== e_bwdata))
        bus_bad = 1'b1;
      if (c == ack_after) begin
        bus_ack_i = 1'b1; bus_rdata_i = rd;
      end
    end
    chk("bus_fields_held", {31'd0, bus_bad}, 32'd0);
    chk("access_completed", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int busy_n, stall_n;

    ctab[0]  = '{4'd0,  32'h0,    32'h1234_5678, 5'd3,  1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    ctab[1]  = '{4'd9,  32'h0,    32'hA5A5_A5A5, 5'd31, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0};
    ctab[2]  = '{4'd15, 32'h0,    32'h0F0F_0F0F, 5'd7,  1'b0, 1'b1, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0};
    ctab[3]  = '{4'd5,  32'h3002, 32'h0,         5'd4,  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    ctab[4]  = '{4'd3,  32'h3001, 32'h0,         5'd4,  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    ctab[5]  = '{4'd4,  32'h3003, 32'h0,         5'd4,  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    ctab[6]  = '{4'd7,  32'h3001, 32'h0,         5'd4,  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    ctab[7]  = '{4'd8,  32'h3002, 32'h0,         5'd4,  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    ctab[8]  = '{4'd1,  32'h3003, 32'h0,         5'd4,  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0};
    ctab[9]  = '{4'd8,  32'h3000, 32'h0,         5'd4,  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0};
    ctab[10] = '{4'd2,  32'h3001, 32'h0,         5'd4,  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0};

    mtab[0]  = '{4'd1, 32'h1001, 32'h0,         32'h11F0_3344, 1, 4'b0100, 32'h0,         1'b0, 32'hFFFF_FFF0};
    mtab[1]  = '{4'd2, 32'h1001, 32'h0,         32'h11F0_3344, 0, 4'b0100, 32'h0,         1'b0, 32'h0000_00F0};
    mtab[2]  = '{4'd1, 32'h1000, 32'h0,         32'h7F00_0000, 0, 4'b1000, 32'h0,         1'b0, 32'h0000_007F};
    mtab[3]  = '{4'd1, 32'h1003, 32'h0,         32'h0000_00A5, 0, 4'b0001, 32'h0,         1'b0, 32'hFFFF_FFA5};
    mtab[4]  = '{4'd2, 32'h1002, 32'h0,         32'h0000_C300, 2, 4'b0010, 32'h0,         1'b0, 32'h0000_00C3};
    mtab[5]  = '{4'd3, 32'h1000, 32'h0,         32'h8001_1234, 0, 4'b1100, 32'h0,         1'b0, 32'hFFFF_8001};
    mtab[6]  = '{4'd4, 32'h1002, 32'h0,         32'h1234_F00D, 0, 4'b0011, 32'h0,         1'b0, 32'h0000_F00D};
    mtab[7]  = '{4'd3, 32'h1002, 32'h0,         32'h1234_F00D, 0, 4'b0011, 32'h0,         1'b0, 32'hFFFF_F00D};
    mtab[8]  = '{4'd5, 32'h1004, 32'h0,         32'hDEAD_BEEF, 0, 4'b1111, 32'h0,         1'b0, 32'hDEAD_BEEF};
    mtab[9]  = '{4'd6, 32'h2001, 32'h1234_56C3, 32'h0,         0, 4'b0100, 32'hC3C3_C3C3, 1'b1, 32'h0000_5555};
    mtab[10] = '{4'd7, 32'h2002, 32'hAAAA_BEEF, 32'h0,         3, 4'b0011, 32'hBEEF_BEEF, 1'b1, 32'h0000_5555};
    mtab[11] = '{4'd8, 32'h2000, 32'hCAFE_F00D, 32'h0,         1, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0000_5555};
    mtab[12] = '{4'd6, 32'h2003, 32'h0000_005A, 32'h0,         0, 4'b0001, 32'h5A5A_5A5A, 1'b1, 32'h0000_5555};

    // Reset holds all outputs low even with pass-through inputs present
    rst = 1'b1; op_i = 4'd0; addr_i = 32'h0; store_data_i = 32'h0; wdata_i = 32'h1234_5678;
    wd_i = 5'd3; wreg_i = 1'b1; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    #12;
    chk("rst_wdata_o", wdata_o, 32'h0);
    chk("rst_wd_wreg_stall", {24'd0, wd_o, wreg_o, stall_req_o, mem_err_o}, 32'h0);
    chk("rst_bus", {bus_req_o, bus_we_o, bus_sel_o} | bus_addr_o | bus_wdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational behaviour in IDLE; op returns to NOP before the next edge
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      op_i = ctab[i].op; addr_i = ctab[i].addr; wdata_i = ctab[i].wdata;
      wd_i = ctab[i].wd; wreg_i = ctab[i].wreg;
      #1;
      if (ctab[i].chk_data) chk($sformatf("idle[%0d]_wdata", i), wdata_o, ctab[i].e_wdata);
      chk($sformatf("idle[%0d]_wd", i), {27'd0, wd_o}, {27'd0, ctab[i].wd});
      chk($sformatf("idle[%0d]_wreg_stall_err_req", i),
          {28'd0, wreg_o, stall_req_o, mem_err_o, bus_req_o},
          {28'd0, ctab[i].e_wreg, ctab[i].e_stall, ctab[i].e_err, 1'b0});
      op_i = 4'd0;
      #1;
      chk($sformatf("idle[%0d]_err_cleared", i), {31'd0, mem_err_o}, 32'd0);
    end

    // Load/store transactions
    wdata_i = 32'h0000_5555; wreg_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      wd_i = 5'(10 + i);
      run_mem(mtab[i].op, mtab[i].addr, mtab[i].sd, mtab[i].rd, mtab[i].ack_after,
              mtab[i].e_sel, mtab[i].e_bwdata, mtab[i].e_we, busy_n, stall_n);
      chk($sformatf("mem[%0d]_busy_cycles", i), busy_n, mtab[i].ack_after + 1);
      chk($sformatf("mem[%0d]_stall_cycles", i), stall_n, mtab[i].ack_after + 2);
      chk($sformatf("mem[%0d]_wdata_o", i), wdata_o, mtab[i].e_wdata);
      chk($sformatf("mem[%0d]_wd_wreg_err_stall", i),
          {24'd0, wd_o, wreg_o, mem_err_o, stall_req_o}, {24'd0, 5'(10 + i), 1'b1, 1'b0, 1'b0});
    end

    // Timeout: no ack for 64 BUSY cycles
    wd_i = 5'd9; wdata_i = 32'h7777_7777;
    run_mem(4'd4, 32'h4002, 32'h0, 32'h1234_BEEF, -1, 4'b0011, 32'h0, 1'b0, busy_n, stall_n);
    chk("timeout_busy_cycles", busy_n, 64);
    chk("timeout_err_wreg_stall", {29'd0, mem_err_o, wreg_o, stall_req_o}, 32'b100);
    chk("timeout_wdata_o", wdata_o, 32'h0);
    op_i = 4'd0;
    @(negedge clk); #1;
    chk("timeout_err_one_cycle", {31'd0, mem_err_o}, 32'd0);

    // Ack on the final BUSY cycle beats the timeout
    run_mem(4'd4, 32'h4002, 32'h0, 32'h1234_BEEF, 63, 4'b0011, 32'h0, 1'b0, busy_n, stall_n);
    chk("lastack_busy_cycles", busy_n, 64);
    chk("lastack_err_wreg", {30'd0, mem_err_o, wreg_o}, 32'b01);
    chk("lastack_wdata_o", wdata_o, 32'h0000_BEEF);

    // bus_ack_i while idle is ignored
    @(negedge clk);
    op_i = 4'd0; wdata_i = 32'hCAFE_0001; wreg_i = 1'b1; bus_ack_i = 1'b1;
    @(negedge clk); #1;
    chk("idle_ack_ignored", {29'd0, stall_req_o, bus_req_o, mem_err_o}, 32'd0);
    chk("idle_ack_passthru", wdata_o, 32'hCAFE_0001);
    bus_ack_i = 1'b0;

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    op_i = 4'd5; addr_i = 32'h5000;
    @(negedge clk); #1;
    chk("pre_rst_busy_req", {31'd0, bus_req_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req_stall", {30'd0, bus_req_o, stall_req_o}, 32'd0);
    @(negedge clk);
    op_i = 4'd0; addr_i = 32'h0; wdata_i = 32'h0; wd_i = 5'd0; wreg_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_outputs", {wdata_o[31:6], wd_o, wreg_o} | {bus_addr_o[31:6], bus_req_o,
        bus_we_o, bus_sel_o} | bus_wdata_o, 32'h0);
    chk("post_rst_flags", {30'd0, stall_req_o, mem_err_o}, 32'd0);
    // FSM is back in IDLE: a fresh NOP passes straight through
    wdata_i = 32'h0BAD_F00D; wreg_i = 1'b1; wd_i = 5'd17;
    @(negedge clk); #1;
    chk("post_rst_idle_passthru", {wdata_o[26:0], wd_o}, {27'h3ADF00D & 27'h7FF_FFFF, 5'd17});
    chk("post_rst_idle_no_req", {30'd0, bus_req_o, stall_req_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
